modmul_arbiter: RTL and testbench
=================================

# modmul_arbiter

Round-robin arbiter that shares one pipelined modular multiplier between NUM_REQ requesters, such as the ECDSA verify sequencer's scalar, inverse and point-arithmetic units. It accepts operand pairs, issues them in order to the multiplier through a registered issue stage, and tracks the owner of each in-flight operation in a tag FIFO. Each result is returned only to the requester that issued it. It is exercised end-to-end by the Wycheproof-vector benches across all curve widths up to 521 bits.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 256: operand/result width in bits (160..521).
- MAX_INFLIGHT, 16: maximum operations granted but not yet returned; also the tag-FIFO depth (power of two).
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester grant; at most one bit high per cycle.
- req_a  in  NUM_REQ*WIDTH  packed operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*WIDTH  packed operand B.
- mul_valid  out  1  issue to the multiplier.
- mul_ready  in  1  multiplier accepts the issue.
- mul_a, mul_b  out  WIDTH  issued operands.
- mul_out_valid  in  1  result valid; results arrive in issue order.
- mul_out  in  WIDTH  result.
- rsp_valid  out  NUM_REQ  one-hot result strobe. There is no backpressure; the requester must take the result.
- rsp_data  out  WIDTH  result, broadcast to all requesters.
- inflight  out  $clog2(MAX_INFLIGHT+1)  current outstanding count.
- err_orphan  out  1  sticky flag; set when mul_out_valid arrives while the tag FIFO is empty.

## Operation
- Issue register (ISS): holds mul_valid, mul_a, mul_b and the owner index. It is free when !mul_valid or (mul_valid && mul_ready).
- can_grant = ISS free && inflight < MAX_INFLIGHT.
- Arbitration is combinational. Requesters are searched from priority pointer ptr upward, modulo NUM_REQ. req_ready[i] = can_grant && i is the first requester with req_valid set. A request is granted on the cycle where req_valid[i] && req_ready[i].
- On a grant from requester g:
  - ISS loads slice g of req_a and req_b;
  - g is pushed into the tag FIFO;
  - inflight increments;
  - ptr becomes (g+1) mod NUM_REQ.
- ptr is unchanged on cycles with no grant.
- ISS holds its contents while mul_valid && !mul_ready. Operands are stable until accepted.
- On mul_out_valid with a non-empty FIFO:
  - the head tag h is popped;
  - on the next cycle rsp_valid = one-hot(h) and rsp_data = mul_out;
  - inflight decrements.
- On mul_out_valid with an empty FIFO: the result is dropped, err_orphan is set, and inflight is unchanged.
- Simultaneous grant and response: push and pop happen in the same cycle and inflight is unchanged. A grant is permitted when inflight == MAX_INFLIGHT and a response arrives in the same cycle only if can_grant already allowed it. It does not, so there is no look-ahead credit.
- inflight counts granted operations, including any still held in ISS.
- Reset, asserted at any time:
  - clears ISS, the FIFO, inflight, ptr and err_orphan;
  - discards all in-flight tags.
  - The multiplier shares rst_n, so no stale results are expected.
- err_orphan clears only on reset.

## Timing
- Reset values:
  - req_ready = 0 while rst_n is low;
  - mul_valid = 0, mul_a = 0, mul_b = 0;
  - rsp_valid = 0, rsp_data = 0;
  - inflight = 0, err_orphan = 0, ptr = 0.
- req_ready depends combinationally on req_valid, mul_valid, mul_ready and inflight. It does not depend on req_a or req_b.
- Grant at cycle t gives mul_valid = 1 at t+1.
- With mul_ready held high, one grant per cycle is sustained, so issue throughput is 1 per cycle.
- mul_out_valid at cycle u gives rsp_valid at u+1, registered. rsp_valid is a single-cycle pulse per result.
- Round-trip latency = 2 + multiplier latency, measured from grant to rsp_valid.

## Test plan
- Single requester: requester 2 sends a=3, b=5 with a stub multiplier of 4-cycle latency returning 15. Required: grant at t, mul_valid at t+1, rsp_valid = 4'b0100 with rsp_data = 15 at t+6, inflight 0 -> 1 -> 0.
- Fairness: all 4 req_valid held high for 8 grants starting with ptr=0. Required: grant order 0,1,2,3,0,1,2,3, with exactly one req_ready bit high per cycle.
- Backpressure: mul_ready held low for 5 cycles with requester 1 valid. Required: mul_a and mul_b stable, req_ready = 0 for all requesters, no second grant; grant resumes on the cycle mul_ready rises.
- Full:
  - MAX_INFLIGHT = 4 with the multiplier never responding. Required: exactly 4 grants, then req_ready = 0 and inflight = 4.
  - One result is then returned. Required: inflight = 3 and exactly one further grant.
- Interleaved ownership: requesters 0 and 3 alternate with a stub that computes a*b. Required: every response is routed to its issuer with the correct product. Also required: a grant and a response in the same cycle leave inflight unchanged.
- Orphan and reset:
  - mul_out_valid pulsed with the FIFO empty. Required: err_orphan = 1 and no rsp_valid.
  - rst_n asserted mid-traffic with 3 in flight. Required: all outputs return to 0 asynchronously and err_orphan clears.

Source files
------------

// File: rtl/modmul_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : modmul_arbiter
//  Purpose  : Round-robin arbiter sharing one pipelined modular multiplier
//             between NUM_REQ requesters. Operand pairs are issued in order
//             through a registered issue stage, and a tag FIFO records the
//             owner of every in-flight operation so that each result is
//             steered back only to the requester that issued it.
//  Revision : 1.0 - initial release
// ============================================================================
module modmul_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 256,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    // Requester side
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0]            req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0]            req_b_i,
    // Multiplier issue side
    output logic                                mul_valid_o,
    input  logic                                mul_ready_i,
    output logic [WIDTH-1:0]                    mul_a_o,
    output logic [WIDTH-1:0]                    mul_b_o,
    // Multiplier result side (results arrive in issue order)
    input  logic                                mul_out_valid_i,
    input  logic [WIDTH-1:0]                    mul_out_i,
    // Response side (no backpressure)
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    output logic [WIDTH-1:0]                    rsp_data_o,
    // Status
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_o,
    output logic                                err_orphan_o
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(NUM_REQ - 1);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Issue stage
    logic                   mul_valid_q, mul_valid_d;
    logic [WIDTH-1:0]       mul_a_q,     mul_a_d;
    logic [WIDTH-1:0]       mul_b_q,     mul_b_d;
    // Round-robin priority pointer
    logic [TAG_W-1:0]       ptr_q,       ptr_d;
    // Outstanding count; doubles as the tag FIFO occupancy
    logic [CNT_W-1:0]       inflight_q,  inflight_d;
    // Tag FIFO pointers and storage
    logic [PTR_W-1:0]       wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,    rd_ptr_d;
    logic [TAG_W-1:0]       tag_mem [MAX_INFLIGHT];
    // Response register
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]       rsp_data_q,  rsp_data_d;
    // Sticky orphan-result flag
    logic                   err_orphan_q, err_orphan_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]       opa [NUM_REQ];
    logic [WIDTH-1:0]       opb [NUM_REQ];
    logic                   iss_free;
    logic                   can_grant;
    logic                   sel_found;
    logic [TAG_W-1:0]       sel_idx;
    int                     cand;
    logic                   grant;
    logic                   pop;
    logic                   orphan;
    logic [TAG_W-1:0]       head_tag;

    // Unpack the per-requester operand slices for indexed selection
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign opa[gi] = req_a_i[gi*WIDTH +: WIDTH];
            assign opb[gi] = req_b_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The issue slot can take a new operation when empty or draining this cycle.
    // Reset gates grants so req_ready stays low while rst_n is held.
    always_comb begin
        iss_free  = !mul_valid_q || mul_ready_i;
        can_grant = rst_ni && iss_free && (inflight_q < CNT_MAX);
    end

    // Round-robin search: first valid requester at or after ptr, wrapping
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!sel_found && req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand[TAG_W-1:0];
            end
        end
    end

    // Grant decode; at most one ready bit can be high
    always_comb begin
        grant       = can_grant && sel_found;
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[sel_idx] = 1'b1;
        end
    end

    // Result bookkeeping: a result pops the owner tag unless nothing is tracked
    always_comb begin
        head_tag = tag_mem[rd_ptr_q];
        pop      = mul_out_valid_i && (inflight_q != CNT_ZERO);
        orphan   = mul_out_valid_i && (inflight_q == CNT_ZERO);
    end

    // Next-state for the issue stage: load on grant, hold while stalled
    always_comb begin
        mul_valid_d = mul_valid_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        if (grant) begin
            mul_valid_d = 1'b1;
            mul_a_d     = opa[sel_idx];
            mul_b_d     = opb[sel_idx];
        end else if (mul_ready_i) begin
            mul_valid_d = 1'b0;
        end
    end

    // Next-state for pointers, outstanding count, response and error flag
    always_comb begin
        ptr_d        = ptr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        inflight_d   = inflight_q;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        err_orphan_d = err_orphan_q || orphan;

        if (grant) begin
            ptr_d    = (sel_idx == TAG_LAST) ? '0 : (sel_idx + TAG_ONE);
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            rsp_valid_d = NUM_REQ'(1) << head_tag;
            rsp_data_d  = mul_out_i;
        end

        // A simultaneous push and pop leave the count unchanged
        case ({grant, pop})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
        endcase
    end

    // Control and datapath registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mul_valid_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            ptr_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            inflight_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            mul_valid_q  <= mul_valid_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            ptr_q        <= ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            inflight_q   <= inflight_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid count
    always_ff @(posedge clk_i) begin
        if (grant) begin
            tag_mem[wr_ptr_q] <= sel_idx;
        end
    end

    // Output drive
    always_comb begin
        mul_valid_o  = mul_valid_q;
        mul_a_o      = mul_a_q;
        mul_b_o      = mul_b_q;
        rsp_valid_o  = rsp_valid_q;
        rsp_data_o   = rsp_data_q;
        inflight_o   = inflight_q;
        err_orphan_o = err_orphan_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_modmul_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_modmul_arbiter
//  Purpose  : Self-checking bench for modmul_arbiter with a 4-cycle stub
//             multiplier, a grant-driven expected-response queue and an
//             independent response monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_modmul_arbiter;

    localparam int NR = 4;
    localparam int W  = 256;
    localparam int MI = 4;
    localparam int CW = $clog2(MI + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [W-1:0]       a_in [NR];
    logic [W-1:0]       b_in [NR];
    logic [NR*W-1:0]    req_a;
    logic [NR*W-1:0]    req_b;
    logic               mul_valid;
    logic               mul_rdy;
    logic [W-1:0]       mul_a;
    logic [W-1:0]       mul_b;
    logic               mul_out_valid;
    logic [W-1:0]       mul_out;
    logic [NR-1:0]      rsp_valid;
    logic [W-1:0]       rsp_data;
    logic [CW-1:0]      inflight;
    logic               err_orphan;

    // stub multiplier controls
    logic               stub_en;
    logic               inj_v;
    logic [W-1:0]       inj_d;
    logic [3:0]         pipe_v;
    logic [W-1:0]       pipe_d [4];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         owner;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    modmul_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_INFLIGHT(MI)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_a_i         (req_a),
        .req_b_i         (req_b),
        .mul_valid_o     (mul_valid),
        .mul_ready_i     (mul_rdy),
        .mul_a_o         (mul_a),
        .mul_b_o         (mul_b),
        .mul_out_valid_i (mul_out_valid),
        .mul_out_i       (mul_out),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .inflight_o      (inflight),
        .err_orphan_o    (err_orphan)
    );

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W] = a_in[i];
            req_b[i*W +: W] = b_in[i];
        end
    end

    // 4-cycle pipelined stub multiplier; stub_en=0 swallows results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
        end else begin
            pipe_v    <= {pipe_v[2:0], mul_valid && mul_rdy && stub_en};
            pipe_d[0] <= mul_a * mul_b;
            for (int k = 1; k < 4; k++) pipe_d[k] <= pipe_d[k-1];
        end
    end
    assign mul_out_valid = pipe_v[3] | inj_v;
    assign mul_out       = inj_v ? inj_d : pipe_d[3];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard feed: every accepted request pushes its expected owner/product
    always @(negedge clk) begin : p_obs
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.owner = i;
                    e.data  = a_in[i] * b_in[i];
                    sb.push_back(e);
                end
            end
        end
    end

    // Monitor: every response must match the oldest expected entry
    always @(negedge clk) begin : p_mon
        exp_t e;
        if (rst_n && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid %b data %0h expected no response", rsp_valid, rsp_data);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", W'(rsp_valid), W'(4'b0001 << e.owner));
                chk("rsp_data", rsp_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        inj_v     = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int c = 0;
        while (sb.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        #1;
        chk("drain_queue_empty", W'(sb.size()), '0);
    endtask

    initial begin : p_main
        int lat, got, cyc, cnt, n0, n3, seen;
        logic           pend;
        logic [CW-1:0]  pinf;
        logic [NR-1:0]  g;

        rst_n     = 1'b0;
        req_valid = '0;
        mul_rdy   = 1'b1;
        stub_en   = 1'b1;
        inj_v     = 1'b0;
        inj_d     = '0;
        for (int i = 0; i < NR; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end

        // ---------------- reset values ----------------
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", W'(req_ready), '0);
        chk("rst_mul_valid", W'(mul_valid), '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_inflight", W'(inflight), '0);
        chk("rst_err_orphan", W'(err_orphan), '0);
        do_reset();

        // ---------------- single requester ----------------
        tick();
        a_in[2] = 3; b_in[2] = 5; req_valid = 4'b0100;
        @(negedge clk);
        chk("single_grant", W'(req_ready), W'(4'b0100));
        chk("single_inflight_t", W'(inflight), '0);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_mul_valid", W'(mul_valid), W'(1'b1));
        chk("single_mul_a", mul_a, W'(3));
        chk("single_mul_b", mul_b, W'(5));
        chk("single_inflight_t1", W'(inflight), W'(1));
        lat = 0;
        while (rsp_valid == '0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("single_latency", W'(lat), W'(5));
        chk("single_rsp_valid", W'(rsp_valid), W'(4'b0100));
        chk("single_rsp_data", rsp_data, W'(15));
        chk("single_inflight_end", W'(inflight), '0);
        @(negedge clk);
        chk("single_rsp_pulse", W'(rsp_valid), '0);

        // ---------------- fairness ----------------
        do_reset();
        tick();
        for (int i = 0; i < NR; i++) begin
            a_in[i] = W'(i + 1);
            b_in[i] = W'(10 + i);
        end
        req_valid = 4'hF;
        got = 0; cyc = 0;
        while (got < 8 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin
                chk("fair_onehot", W'($onehot(req_ready)), W'(1));
                chk("fair_order", W'(req_ready), W'(4'b0001 << (got % 4)));
                got++;
            end
        end
        chk("fair_grant_count", W'(got), W'(8));
        tick();
        req_valid = '0;
        drain();

        // ---------------- backpressure ----------------
        do_reset();
        mul_rdy = 1'b0;
        tick();
        a_in[1] = 11; b_in[1] = 13; req_valid = 4'b0010;
        @(negedge clk);
        chk("bp_first_grant", W'(req_ready), W'(4'b0010));
        tick();
        a_in[1] = 21;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_no_grant", W'(req_ready), '0);
            chk("bp_mul_valid", W'(mul_valid), W'(1'b1));
            chk("bp_mul_a_stable", mul_a, W'(11));
            chk("bp_mul_b_stable", mul_b, W'(13));
            @(negedge clk);
        end
        tick();
        mul_rdy = 1'b1;
        @(negedge clk);
        chk("bp_grant_resumes", W'(req_ready), W'(4'b0010));
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("bp_second_op", mul_a, W'(21));
        drain();

        // ---------------- interleaved ownership ----------------
        do_reset();
        tick();
        n0 = 0; n3 = 0; got = 0; cyc = 0; seen = 0; pend = 1'b0; pinf = '0;
        a_in[0] = W'(2);  b_in[0] = W'(1000);
        a_in[3] = W'(3);  b_in[3] = (W'(1) << 100);
        req_valid = 4'b1001;
        while ((got < 8 || pend) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            g = req_valid & req_ready;
            if (pend) begin
                chk("inter_same_cycle_inflight", W'(inflight), W'(pinf));
                pend = 1'b0;
            end
            if (g != '0 && mul_out_valid && inflight != '0) begin
                pend = 1'b1;
                pinf = inflight;
                seen++;
            end
            if (g != '0) begin
                chk("inter_order", W'(g), (got % 2 == 0) ? W'(4'b0001) : W'(4'b1000));
                got++;
            end
            tick();
            if (g[0]) begin
                n0++;
                a_in[0] = W'(2 + 2 * n0);
                b_in[0] = W'(1000 + n0);
                if (n0 >= 4) req_valid[0] = 1'b0;
            end
            if (g[3]) begin
                n3++;
                a_in[3] = W'(3 + 2 * n3);
                b_in[3] = (W'(1) << 100) + W'(n3);
                if (n3 >= 4) req_valid[3] = 1'b0;
            end
        end
        req_valid = '0;
        chk("inter_grant_count", W'(got), W'(8));
        n_tests++;
        if (seen == 0) begin
            n_fail++;
            $display("FAIL inter_same_cycle_seen: got %0d coincident grant/response cycles expected at least 1", seen);
        end
        drain();

        // ---------------- full ----------------
        do_reset();
        stub_en = 1'b0;
        tick();
        a_in[0] = 7; b_in[0] = 9; req_valid = 4'b0001;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (req_ready[0]) cnt++;
        end
        chk("full_grant_count", W'(cnt), W'(4));
        chk("full_inflight", W'(inflight), W'(4));
        chk("full_no_ready", W'(req_ready), '0);
        tick();
        inj_d = W'(63); inj_v = 1'b1;
        @(negedge clk);
        tick();
        inj_v = 1'b0;
        @(negedge clk);
        chk("full_after_rsp_inflight", W'(inflight), W'(3));
        cnt = 0;
        repeat (8) begin
            if (req_ready[0]) cnt++;
            @(negedge clk);
        end
        chk("full_one_more_grant", W'(cnt), W'(1));
        chk("full_inflight_refill", W'(inflight), W'(4));

        // ---------------- orphan ----------------
        do_reset();
        stub_en = 1'b1;
        tick();
        inj_d = W'(5); inj_v = 1'b1;
        @(negedge clk);
        tick();
        inj_v = 1'b0;
        @(negedge clk);
        chk("orphan_flag", W'(err_orphan), W'(1'b1));
        chk("orphan_no_rsp", W'(rsp_valid), '0);
        chk("orphan_inflight", W'(inflight), '0);
        repeat (3) @(negedge clk);
        chk("orphan_sticky", W'(err_orphan), W'(1'b1));

        // ---------------- reset mid-traffic ----------------
        stub_en = 1'b0;
        tick();
        a_in[2] = 4; b_in[2] = 6; req_valid = 4'b0100;
        cnt = 0; cyc = 0;
        while (cnt < 3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (req_ready[2]) cnt++;
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        chk("mid_inflight3", W'(inflight), W'(3));
        req_valid = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", W'(req_ready), '0);
        chk("mid_rst_mul_valid", W'(mul_valid), '0);
        chk("mid_rst_mul_a", mul_a, '0);
        chk("mid_rst_mul_b", mul_b, '0);
        chk("mid_rst_rsp_valid", W'(rsp_valid), '0);
        chk("mid_rst_rsp_data", rsp_data, '0);
        chk("mid_rst_inflight", W'(inflight), '0);
        chk("mid_rst_err_orphan", W'(err_orphan), '0);
        sb.delete();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
